// File: rtl/uart_baud_pkg.sv
// uart_baud_pkg: shared constants for the UART fractional baud generator.
//   BAUD_OVERSAMPLE       - rx enables per tx bit enable
//   BAUD_DIV_INT_W/FRAC_W - divisor field widths
//   BAUD_DEFAULT_DIV_*    - divisor loaded by reset (50 MHz, 115200 baud)
//   baud_div_fixed()      - constant function: clock/baud -> fixed-point divisor
package uart_baud_pkg;

  localparam int unsigned BAUD_OVERSAMPLE  = 16;
  localparam int unsigned BAUD_DIV_INT_W   = 16;
  localparam int unsigned BAUD_DIV_FRAC_W  = 4;

  // Returns round(clk_hz * 2^frac_w / (baud * oversample)); the integer part is
  // result >> frac_w and the fractional part is the low frac_w bits.
  function automatic longint unsigned baud_div_fixed(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input int unsigned     oversample,
    input int unsigned     frac_w
  );
    longint unsigned den;
    den = baud * longint'(oversample);
    return ((clk_hz << frac_w) + (den >> 1)) / den;
  endfunction

  localparam longint unsigned BAUD_DEFAULT_FIXED =
    baud_div_fixed(64'd50_000_000, 64'd115_200, BAUD_OVERSAMPLE, BAUD_DIV_FRAC_W);

  // 27.125 clocks per rx enable.
  localparam int unsigned BAUD_DEFAULT_DIV_INT  = int'(BAUD_DEFAULT_FIXED >> BAUD_DIV_FRAC_W);
  localparam int unsigned BAUD_DEFAULT_DIV_FRAC =
    int'(BAUD_DEFAULT_FIXED & ((64'd1 << BAUD_DIV_FRAC_W) - 64'd1));

endpackage

// File: rtl/frac_tick_gen.sv
// frac_tick_gen: fractional period counter. Emits a combinational tick on the
// cycle whose rising edge ends an rx period of eff_int + carry clocks.
//   clk           - system clock
//   rst           - synchronous active-high reset
//   run           - count this cycle (enable)
//   clear         - restart phase: counter and accumulator to zero
//   frac_clr      - on the tick edge, zero the accumulator instead of adding
//   div_int       - active integer divisor (0/1 clamp to 2)
//   div_frac      - active fractional divisor
//   tick          - this edge ends a period
module frac_tick_gen
  import uart_baud_pkg::*;
#(
  parameter int unsigned INT_W  = BAUD_DIV_INT_W,
  parameter int unsigned FRAC_W = BAUD_DIV_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              clear,
  input  logic              frac_clr,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick
);

  // One extra bit: the longest period is (2^INT_W - 1) + 1 clocks.
  logic [INT_W:0]  rx_cnt_q, rx_cnt_d;
  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic [FRAC_W:0] frac_sum;
  logic [INT_W:0]  eff_int;
  logic [INT_W:0]  period_m1;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    frac_sum   = {1'b0, frac_acc_q} + {1'b0, div_frac};
    eff_int    = (div_int < INT_W'(2)) ? (INT_W + 1)'(2) : {1'b0, div_int};
    // The accumulator carry stretches this period by one clock.
    period_m1  = eff_int + (INT_W + 1)'(frac_sum[FRAC_W]) - (INT_W + 1)'(1);
    tick       = run && !clear && (rx_cnt_q == period_m1);
    rx_cnt_d   = rx_cnt_q;
    frac_acc_d = frac_acc_q;
    if (clear) begin
      rx_cnt_d   = '0;
      frac_acc_d = '0;
    end else if (tick) begin
      rx_cnt_d   = '0;
      frac_acc_d = frac_clr ? '0 : frac_sum[FRAC_W-1:0];
    end else if (run) begin
      rx_cnt_d   = rx_cnt_q + (INT_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      rx_cnt_q   <= '0;
      frac_acc_q <= '0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      frac_acc_q <= frac_acc_d;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: runtime-programmable fractional baud-rate generator.
//   clk_50m     - system clock
//   rst         - synchronous active-high reset
//   enable      - run; when low counters hold and enables are 0
//   resync      - restart phase; applies any pending divisor at once
//   div_wr      - strobe: latch div_int_in/div_frac_in into the shadow
//   div_int_in  - new integer divisor
//   div_frac_in - new fractional divisor
//   div_pending - shadow written but not yet active
//   rxclk_en    - one-cycle oversample enable (registered)
//   txclk_en    - one-cycle bit enable, coincident with rxclk_en (registered)
module baud_gen_frac
  import uart_baud_pkg::*;
#(
  parameter int unsigned OVERSAMPLE       = BAUD_OVERSAMPLE,
  parameter int unsigned DIV_INT_W        = BAUD_DIV_INT_W,
  parameter int unsigned DIV_FRAC_W       = BAUD_DIV_FRAC_W,
  parameter int unsigned DEFAULT_DIV_INT  = BAUD_DEFAULT_DIV_INT,
  parameter int unsigned DEFAULT_DIV_FRAC = BAUD_DEFAULT_DIV_FRAC
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  resync,
  input  logic                  div_wr,
  input  logic [DIV_INT_W-1:0]  div_int_in,
  input  logic [DIV_FRAC_W-1:0] div_frac_in,
  output logic                  div_pending,
  output logic                  rxclk_en,
  output logic                  txclk_en
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);

  logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
  logic [DIV_INT_W-1:0]  act_int_q, act_int_d, sh_int_q, sh_int_d;
  logic [DIV_FRAC_W-1:0] act_frac_q, act_frac_d, sh_frac_q, sh_frac_d;
  logic                  pending_q, pending_d;
  logic                  rx_en_q, rx_en_d;
  logic                  tx_en_q, tx_en_d;
  logic                  tick;
  logic                  os_last;
  logic                  apply_on_tick;

  assign os_last = (os_cnt_q == OS_W'(OVERSAMPLE - 1));
  // A pending shadow is swapped in only on a tx bit boundary.
  assign apply_on_tick = pending_q && os_last;

  frac_tick_gen #(
    .INT_W  (DIV_INT_W),
    .FRAC_W (DIV_FRAC_W)
  ) u_tick (
    .clk      (clk_50m),
    .rst      (rst),
    .run      (enable),
    .clear    (resync),
    .frac_clr (apply_on_tick),
    .div_int  (act_int_q),
    .div_frac (act_frac_q),
    .tick     (tick)
  );

  always_comb begin
    os_cnt_d   = os_cnt_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pending_d  = pending_q;
    rx_en_d    = 1'b0;
    tx_en_d    = 1'b0;
    if (resync) begin
      os_cnt_d  = '0;
      pending_d = 1'b0;
      if (div_wr) begin
        // A write in the resync cycle bypasses the shadow.
        act_int_d  = div_int_in;
        act_frac_d = div_frac_in;
        sh_int_d   = div_int_in;
        sh_frac_d  = div_frac_in;
      end else begin
        act_int_d  = sh_int_q;
        act_frac_d = sh_frac_q;
      end
    end else begin
      if (tick) begin
        os_cnt_d = os_cnt_q + OS_W'(1);
        rx_en_d  = 1'b1;
        tx_en_d  = os_last;
        if (apply_on_tick) begin
          act_int_d  = sh_int_q;
          act_frac_d = sh_frac_q;
          pending_d  = 1'b0;
        end
      end
      // Placed after the apply so a coincident write stays pending.
      if (div_wr) begin
        sh_int_d  = div_int_in;
        sh_frac_d = div_frac_in;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      os_cnt_q   <= '0;
      act_int_q  <= DIV_INT_W'(DEFAULT_DIV_INT);
      act_frac_q <= DIV_FRAC_W'(DEFAULT_DIV_FRAC);
      sh_int_q   <= DIV_INT_W'(DEFAULT_DIV_INT);
      sh_frac_q  <= DIV_FRAC_W'(DEFAULT_DIV_FRAC);
      pending_q  <= 1'b0;
      rx_en_q    <= 1'b0;
      tx_en_q    <= 1'b0;
    end else begin
      os_cnt_q   <= os_cnt_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pending_q  <= pending_d;
      rx_en_q    <= rx_en_d;
      tx_en_q    <= tx_en_d;
    end
  end

  assign div_pending = pending_q;
  assign rxclk_en    = rx_en_q;
  assign txclk_en    = tx_en_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: self-checking bench for baud_gen_frac. Pulse intervals are
// predicted from the closed-form rule: the n-th period after a phase start is
// eff_int + floor(n*frac/2^F) - floor((n-1)*frac/2^F).
module tb_baud_gen_frac;

  localparam int INT_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OS     = 16;
  localparam int BUDGET = 500;

  logic              clk_50m = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              resync = 1'b0;
  logic              div_wr = 1'b0;
  logic [INT_W-1:0]  div_int_in = '0;
  logic [FRAC_W-1:0] div_frac_in = '0;
  logic              div_pending, rxclk_en, txclk_en;

  always #10 clk_50m = ~clk_50m;

  baud_gen_frac #(
    .OVERSAMPLE(OS), .DIV_INT_W(INT_W), .DIV_FRAC_W(FRAC_W),
    .DEFAULT_DIV_INT(27), .DEFAULT_DIV_FRAC(2)
  ) dut (
    .clk_50m(clk_50m), .rst(rst), .enable(enable), .resync(resync),
    .div_wr(div_wr), .div_int_in(div_int_in), .div_frac_in(div_frac_in),
    .div_pending(div_pending), .rxclk_en(rxclk_en), .txclk_en(txclk_en)
  );

  int compared = 0;
  int mismatched = 0;
  int edge_no = 0;
  int last_rx = 0;
  int rx_iv[$];
  bit rx_tx[$];
  bit rx_pend[$];

  function automatic int exp_interval(input int di, input int df, input int n);
    int eff;
    eff = (di < 2) ? 2 : di;
    return eff + (n * df) / (1 << FRAC_W) - ((n - 1) * df) / (1 << FRAC_W);
  endfunction

  // One clock; samples 1 time unit after the edge and logs any rx pulse.
  task automatic step();
    @(posedge clk_50m);
    #1;
    edge_no++;
    compared++;
    if (txclk_en && !rxclk_en) begin
      mismatched++;
      $display("FAIL tx_coincident: txclk_en=%b rxclk_en=%b, required rxclk_en=1 at edge %0d",
               txclk_en, rxclk_en, edge_no);
    end
    if (rxclk_en) begin
      rx_iv.push_back(edge_no - last_rx);
      rx_tx.push_back(txclk_en);
      rx_pend.push_back(div_pending);
      last_rx = edge_no;
    end
  endtask

  task automatic flush(input int origin);
    rx_iv.delete();
    rx_tx.delete();
    rx_pend.delete();
    last_rx = origin;
  endtask

  task automatic get_pulse(output int iv, output bit tx, output bit pend);
    int n = 0;
    while (rx_iv.size() == 0 && n < BUDGET) begin
      step();
      n++;
    end
    if (rx_iv.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL pulse_timeout: no rxclk_en within %0d cycles, required a pulse", BUDGET);
      iv = -1; tx = 1'b0; pend = 1'b0;
    end else begin
      iv   = rx_iv.pop_front();
      tx   = rx_tx.pop_front();
      pend = rx_pend.pop_front();
    end
  endtask

  task automatic write_div(input int di, input int df);
    div_int_in  = INT_W'(di);
    div_frac_in = FRAC_W'(df);
    div_wr = 1'b1;
    step();
    div_wr = 1'b0;
  endtask

  task automatic do_resync();
    resync = 1'b1;
    step();
    resync = 1'b0;
    flush(edge_no);
  endtask

  // Checks 'count' pulses of a phase against the closed-form intervals.
  task automatic check_phase(input string name, input int di, input int df,
                             input int first_n, input int count);
    int iv; bit tx; bit pend;
    for (int n = first_n; n < first_n + count; n++) begin
      get_pulse(iv, tx, pend);
      compared++;
      if (iv !== exp_interval(di, df, n)) begin
        mismatched++;
        $display("FAIL %s_interval[%0d]: got %0d, required %0d", name, n, iv, exp_interval(di, df, n));
      end
      compared++;
      if (tx !== ((n % OS) == 0)) begin
        mismatched++;
        $display("FAIL %s_tx[%0d]: got %b, required %b", name, n, tx, (n % OS) == 0);
      end
    end
  endtask

  // Consumes pulses up to and including the next tx pulse.
  task automatic pull_until_tx(input string name, input bit chk_pend);
    int iv; bit tx; bit pend; bit found;
    found = 1'b0;
    for (int k = 0; k < OS + 1 && !found; k++) begin
      get_pulse(iv, tx, pend);
      if (chk_pend) begin
        compared++;
        if (pend !== !tx) begin
          mismatched++;
          $display("FAIL %s_pending: got %b at pulse tx=%b, required %b", name, pend, tx, !tx);
        end
      end
      found = tx;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL %s_tx_boundary: txclk_en not seen within %0d rx pulses, required 1", name, OS + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if ({rxclk_en, txclk_en, div_pending} !== 3'b000) begin
        mismatched++;
        $display("FAIL reset_outputs: got rx=%b tx=%b pend=%b, required 000", rxclk_en, txclk_en, div_pending);
      end
    end
    rst = 1'b0;
    enable = 1'b1;
    flush(edge_no);
  endtask

  task automatic test_default();
    int total;
    total = 0;
    for (int n = 1; n <= OS; n++) total += exp_interval(27, 2, n);
    compared++;
    if (total !== 434) begin
      mismatched++;
      $display("FAIL default_model_total: got %0d, required 434", total);
    end
    check_phase("default", 27, 2, 1, 2 * OS);
  endtask

  task automatic test_div_update();
    int iv; bit tx; bit pend;
    for (int i = 0; i < 3; i++) get_pulse(iv, tx, pend);
    for (int i = 0; i < 4; i++) step();
    write_div(10, 0);
    compared++;
    if (div_pending !== 1'b1) begin
      mismatched++;
      $display("FAIL update_pending_set: got %b, required 1", div_pending);
    end
    pull_until_tx("update", 1'b1);
    check_phase("update", 10, 0, 1, OS);
    compared++;
    if (edge_no - last_rx !== 0 || div_pending !== 1'b0) begin
      mismatched++;
      $display("FAIL update_after: got pend=%b, required 0", div_pending);
    end
  endtask

  task automatic test_hold();
    int iv; bit tx; bit pend;
    for (int i = 0; i < 3; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      compared++;
      if (rxclk_en !== 1'b0 || txclk_en !== 1'b0) begin
        mismatched++;
        $display("FAIL hold_quiet: got rx=%b tx=%b, required 00", rxclk_en, txclk_en);
      end
    end
    enable = 1'b1;
    get_pulse(iv, tx, pend);
    compared++;
    if (iv !== 15) begin
      mismatched++;
      $display("FAIL hold_interval: got %0d, required 15", iv);
    end
    get_pulse(iv, tx, pend);
    compared++;
    if (iv !== 10) begin
      mismatched++;
      $display("FAIL hold_resume: got %0d, required 10", iv);
    end
  endtask

  task automatic test_clamp();
    write_div(0, 0);
    do_resync();
    compared++;
    if (div_pending !== 1'b0 || rxclk_en !== 1'b0) begin
      mismatched++;
      $display("FAIL clamp_resync: got pend=%b rx=%b, required 00", div_pending, rxclk_en);
    end
    check_phase("clamp", 0, 0, 1, 2 * OS);
  endtask

  task automatic test_resync();
    write_div(5, 0);
    compared++;
    if (div_pending !== 1'b1) begin
      mismatched++;
      $display("FAIL resync_pending_set: got %b, required 1", div_pending);
    end
    do_resync();
    compared++;
    if (div_pending !== 1'b0 || rxclk_en !== 1'b0 || txclk_en !== 1'b0) begin
      mismatched++;
      $display("FAIL resync_clear: got pend=%b rx=%b tx=%b, required 000", div_pending, rxclk_en, txclk_en);
    end
    check_phase("resync", 5, 0, 1, 3);
  endtask

  task automatic test_midop_reset();
    step();
    write_div(9, 0);
    rst = 1'b1;
    step();
    compared++;
    if ({rxclk_en, txclk_en, div_pending} !== 3'b000) begin
      mismatched++;
      $display("FAIL midreset_outputs: got rx=%b tx=%b pend=%b, required 000", rxclk_en, txclk_en, div_pending);
    end
    rst = 1'b0;
    flush(edge_no);
    check_phase("midreset", 27, 2, 1, 2 * OS);
  endtask

  task automatic test_back_to_back();
    write_div(12, 0);
    step();
    write_div(20, 0);
    pull_until_tx("b2b", 1'b1);
    check_phase("b2b", 20, 0, 1, 4);
  endtask

  task automatic test_coincident();
    int iv; bit tx; bit pend;
    write_div(7, 0);
    for (int n = 5; n <= OS - 1; n++) get_pulse(iv, tx, pend);
    // The tx boundary edge is exactly 20 edges after pulse 15.
    for (int i = 0; i < 19; i++) step();
    div_int_in = INT_W'(3);
    div_frac_in = '0;
    div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    get_pulse(iv, tx, pend);
    compared++;
    if (iv !== 20 || tx !== 1'b1 || div_pending !== 1'b1) begin
      mismatched++;
      $display("FAIL coincident_edge: got iv=%0d tx=%b pend=%b, required 20 1 1", iv, tx, div_pending);
    end
    check_phase("coincident_old", 7, 0, 1, OS);
    compared++;
    if (div_pending !== 1'b0) begin
      mismatched++;
      $display("FAIL coincident_applied: got pend=%b, required 0", div_pending);
    end
    check_phase("coincident_new", 3, 0, 1, 2);
  endtask

  task automatic test_random();
    int di, df;
    pull_until_tx("rand_sync", 1'b0);
    for (int it = 0; it < 5; it++) begin
      di = int'($urandom_range(0, 40));
      df = int'($urandom_range(0, (1 << FRAC_W) - 1));
      write_div(di, df);
      pull_until_tx("rand", 1'b1);
      check_phase("rand", di, df, 1, OS);
      // Final pulse of that phase was a tx boundary; re-sync bookkeeping
      // with a tx-free wait is not needed since check_phase ended on n=16.
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_div_update();
    test_hold();
    test_clamp();
    test_resync();
    test_midop_reset();
    test_back_to_back();
    test_coincident();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
